// File: rtl/p2_sprite_render.sv
// Sprite renderer: two-stage pixel pipeline against a registered action ROM,
// plus an animation FSM that loops walk actions and plays punch/kick once.
module p2_sprite_render #(
  parameter int ANIM_DIV    = 8,
  parameter int SCALE_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       frame_tick,
  input  logic [2:0] action_req,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       facing,
  output logic [9:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       pixel_on,
  output logic [2:0] cur_action,
  output logic       busy,
  output logic       action_done
);

  localparam int DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  typedef enum logic {S_LOOP, S_ONESHOT} state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_action, w_action_nxt;
  logic [1:0]         r_frame, w_frame_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic               r_done, w_done_nxt;
  logic               r_inside_p1;
  logic [2:0]         r_col_p1;
  logic               r_pixel_on_p2;

  logic signed [10:0] w_dx, w_dy;
  logic               w_inside;
  logic [2:0]         w_row, w_col, w_col_sel;
  logic [2:0]         w_req;
  logic               w_step;

  // Stage 0: sprite-relative coordinates and ROM address
  assign w_dx      = $signed({1'b0, pixel_x}) - $signed({1'b0, pos_x});
  assign w_dy      = $signed({1'b0, pixel_y}) - $signed({1'b0, pos_y});
  assign w_inside  = (w_dx[10:SCALE_SHIFT+3] == '0) && (w_dy[10:SCALE_SHIFT+3] == '0);
  assign w_row     = w_dy[SCALE_SHIFT+2:SCALE_SHIFT];
  assign w_col     = w_dx[SCALE_SHIFT+2:SCALE_SHIFT];
  assign w_col_sel = facing ? ~w_col : w_col;
  assign rom_addr  = {1'b0, w_row, r_action, 1'b0, r_frame};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inside_p1   <= 1'b0;
      r_col_p1      <= '0;
      r_pixel_on_p2 <= 1'b0;
    end else begin
      r_inside_p1   <= w_inside;
      r_col_p1      <= w_col_sel;
      // Stage 1: ROM word arrives now; bit 7 is the leftmost column
      r_pixel_on_p2 <= r_inside_p1 & rom_data[3'd7 - r_col_p1];
    end
  end

  assign pixel_on = r_pixel_on_p2;

  // Animation control
  assign w_req  = (action_req > 3'd4) ? 3'd0 : action_req;
  assign w_step = frame_tick && (r_div == DIV_W'(ANIM_DIV - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_action_nxt = r_action;
    w_frame_nxt  = r_frame;
    w_div_nxt    = r_div;
    w_done_nxt   = 1'b0;
    case (r_state)
      S_LOOP: begin
        // A change of action restarts the animation and swallows any tick
        if (w_req != r_action) begin
          w_action_nxt = w_req;
          w_frame_nxt  = '0;
          w_div_nxt    = '0;
          if (w_req >= 3'd3) w_state_nxt = S_ONESHOT;
        end else if (frame_tick) begin
          if (w_step) begin
            w_div_nxt   = '0;
            w_frame_nxt = r_frame + 2'd1;
          end else begin
            w_div_nxt = r_div + DIV_W'(1);
          end
        end
      end
      S_ONESHOT: begin
        if (frame_tick) begin
          if (w_step) begin
            w_div_nxt = '0;
            if (r_frame == 2'd3) begin
              w_state_nxt  = S_LOOP;
              w_action_nxt = 3'd0;
              w_frame_nxt  = '0;
              w_done_nxt   = 1'b1;
            end else begin
              w_frame_nxt = r_frame + 2'd1;
            end
          end else begin
            w_div_nxt = r_div + DIV_W'(1);
          end
        end
      end
      default: w_state_nxt = S_LOOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_LOOP;
      r_action <= 3'd0;
      r_frame  <= '0;
      r_div    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_action <= w_action_nxt;
      r_frame  <= w_frame_nxt;
      r_div    <= w_div_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign cur_action  = r_action;
  assign busy        = (r_state == S_ONESHOT);
  assign action_done = r_done;

endmodule

// File: tb/tb_p2_sprite_render.sv
// Bench for p2_sprite_render: directed scenarios then randomized traffic,
// checked against a tick-counting animation model and an arithmetic pixel model.
module tb_p2_sprite_render;

  localparam int DIV = 8;
  localparam int SS  = 3;
  localparam int SPR = 8 << SS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pixel_x = '0, pixel_y = '0, pos_x = '0, pos_y = '0;
  logic       frame_tick = 1'b0, facing = 1'b0;
  logic [2:0] action_req = '0;
  logic [9:0] rom_addr;
  logic [7:0] rom_data = '0;
  logic       pixel_on, busy, action_done;
  logic [2:0] cur_action;

  logic [7:0] rom [1024];

  int n_chk = 0, n_fail = 0;
  // Model state: action shown, ticks accepted since it started, one-shot flag
  int m_act = 0, m_t = 0, m_busy = 0, m_done = 0;
  bit m_pipe = 1'b0;

  p2_sprite_render #(.ANIM_DIV(DIV), .SCALE_SHIFT(SS)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_tick(frame_tick), .action_req(action_req), .pos_x(pos_x),
    .pos_y(pos_y), .facing(facing), .rom_addr(rom_addr), .rom_data(rom_data),
    .pixel_on(pixel_on), .cur_action(cur_action), .busy(busy),
    .action_done(action_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_frame();
    return (m_t / DIV) % 4;
  endfunction

  function automatic int m_addr();
    int dy = (int'(pixel_y) - int'(pos_y)) & 2047;
    return ((dy >> SS) & 7) * 64 + m_act * 8 + m_frame();
  endfunction

  function automatic bit model_pix();
    int dx = int'(pixel_x) - int'(pos_x);
    int dy = int'(pixel_y) - int'(pos_y);
    int col;
    if (!rst_n) return 1'b0;
    if (dx < 0 || dx >= SPR || dy < 0 || dy >= SPR) return 1'b0;
    col = dx >> SS;
    return facing ? rom[m_addr()][col] : rom[m_addr()][7 - col];
  endfunction

  task automatic model_update();
    int req = (action_req > 4) ? 0 : int'(action_req);
    m_done = 0;
    if (!rst_n) begin
      m_act = 0; m_t = 0; m_busy = 0;
    end else if (m_busy != 0) begin
      if (frame_tick) begin
        m_t++;
        if (m_t == 4 * DIV) begin
          m_busy = 0; m_act = 0; m_t = 0; m_done = 1;
        end
      end
    end else if (req != m_act) begin
      m_act = req; m_t = 0; m_busy = (req >= 3) ? 1 : 0;
    end else if (frame_tick) begin
      m_t = (m_t + 1) % (4 * DIV);
    end
  endtask

  task automatic cyc();
    bit e;
    e = model_pix();
    model_update();
    @(posedge clk);
    #1;
    chk("pixel_on", 32'(pixel_on), 32'(m_pipe));
    m_pipe = e;
    chk("cur_action", 32'(cur_action), 32'(m_act));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("action_done", 32'(action_done), 32'(m_done));
    chk("rom_addr", 32'(rom_addr), 32'(m_addr()));
  endtask

  task automatic set_pix(input int x, input int y, input bit f);
    pixel_x = 10'(x); pixel_y = 10'(y); facing = f;
  endtask

  initial begin
    int busy_ticks, n_done, seen, last, nseq, bound;
    int seq [8];
    logic [9:0] a;

    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    rom[192] = 8'b01111100;
    rom[256] = 8'b10010110;

    // Reset state
    pos_x = 10'd100; pos_y = 10'd50;
    set_pix(100, 50, 1'b0);
    repeat (3) cyc();
    chk("rst_pixel_on", 32'(pixel_on), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(rom_addr), 32'd0);
    rst_n = 1'b1;
    cyc();

    // Pixel path, stay action, frame 0
    set_pix(124, 74, 1'b0);
    #1 chk("addr_o300", 32'(rom_addr), 32'o300);
    cyc(); cyc();
    chk("pix_124_74", 32'(pixel_on), 32'd1);
    set_pix(99, 74, 1'b0);
    cyc(); cyc();
    chk("pix_left_edge", 32'(pixel_on), 32'd0);
    set_pix(163, 113, 1'b0);
    #1 a = rom_addr;
    chk("row7", 32'(a[8:6]), 32'd7);
    cyc(); cyc();
    chk("pix_corner", 32'(pixel_on), 32'(rom[448][0]));
    set_pix(100, 82, 1'b1);
    cyc(); cyc();
    chk("mirror_on", 32'(pixel_on), 32'd0);
    set_pix(100, 82, 1'b0);
    cyc(); cyc();
    chk("mirror_off", 32'(pixel_on), 32'd1);

    // Punch one-shot
    set_pix(100, 50, 1'b0);
    action_req = 3'd3;
    cyc();
    action_req = 3'd0;
    busy_ticks = 0; n_done = 0; seen = 0;
    repeat (4 * DIV) begin
      frame_tick = 1'b1;
      if (busy) begin
        busy_ticks++;
        a = rom_addr;
        seen |= 1 << a[1:0];
      end
      cyc();
      if (action_done) n_done++;
      frame_tick = 1'b0;
      cyc();
      if (action_done) n_done++;
    end
    a = rom_addr;
    chk("punch_ticks", 32'(busy_ticks), 32'(4 * DIV));
    chk("punch_frames", 32'(seen), 32'hF);
    chk("punch_done_cnt", 32'(n_done), 32'd1);
    chk("punch_end_act", 32'(cur_action), 32'd0);
    chk("punch_end_frame", 32'(a[2:0]), 32'd0);

    // Forward loop, then switch to backward at frame 2
    action_req = 3'd1;
    cyc();
    a = rom_addr; last = a[2:0]; nseq = 1; seq[0] = last;
    repeat (40) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
      a = rom_addr;
      if (int'(a[2:0]) != last && nseq < 8) begin
        last = a[2:0]; seq[nseq] = last; nseq++;
      end
    end
    chk("fwd_nseq", 32'(nseq >= 5), 32'd1);
    for (int i = 0; i < 5; i++) chk("fwd_seq", 32'(seq[i]), 32'(i % 4));
    bound = 0;
    a = rom_addr;
    while (a[2:0] != 3'd2 && bound < 64) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0;
      a = rom_addr; bound++;
    end
    chk("fwd_reach_f2", 32'(a[2:0]), 32'd2);
    action_req = 3'd2; frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    a = rom_addr;
    chk("bwd_frame0", 32'(a[2:0]), 32'd0);
    chk("bwd_action", 32'(cur_action), 32'd2);
    repeat (DIV - 1) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    end

    // Kick aborted by reset at frame 2
    set_pix(108, 58, 1'b0);
    action_req = 3'd4;
    cyc();
    action_req = 3'd0;
    repeat (2 * DIV + 3) begin
      frame_tick = 1'b1; cyc(); frame_tick = 1'b0; cyc();
    end
    a = rom_addr;
    chk("kick_frame2", 32'(a[2:0]), 32'd2);
    chk("kick_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    m_act = 0; m_t = 0; m_busy = 0; m_pipe = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_action", 32'(cur_action), 32'd0);
    chk("abort_done", 32'(action_done), 32'd0);
    chk("abort_pixel", 32'(pixel_on), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    n_done = 0;
    repeat (4 * DIV) begin
      frame_tick = 1'b1; cyc(); if (action_done) n_done++;
      frame_tick = 1'b0; cyc(); if (action_done) n_done++;
    end
    chk("abort_no_done", 32'(n_done), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) action_req = 3'($urandom_range(0, 7));
      frame_tick = ($urandom_range(0, 3) == 0);
      pos_x = 10'($urandom_range(0, 1023));
      pos_y = 10'($urandom_range(0, 1023));
      pixel_x = 10'(int'(pos_x) + int'($urandom_range(0, 79)) - 8);
      pixel_y = 10'(int'(pos_y) + int'($urandom_range(0, 79)) - 8);
      facing = 1'($urandom_range(0, 1));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
